// File: rtl/ysyx_22050078_pipe_ctrl.sv
// Pipeline hazard/stall controller: PC and IF/ID, ID/EX, EX/MEM, MEM/WB write-enable and bubble.
// Build option YSYX_22050078_FORWARD_EN: datapath forwards, so only load-use stalls.
module ysyx_22050078_pipe_ctrl #(
    parameter int unsigned RST_HOLD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] i_idu_rs1,
    input  logic [4:0] i_idu_rs2,
    input  logic       i_idu_rs1_ren,
    input  logic       i_idu_rs2_ren,
    input  logic [4:0] i_idex_rd,
    input  logic       i_idex_rd_wen,
    input  logic       i_idex_is_load,
    input  logic [4:0] i_exmem_rd,
    input  logic       i_exmem_rd_wen,
    input  logic [4:0] i_memwb_rd,
    input  logic       i_memwb_rd_wen,
    input  logic       i_exu_redirect,
    input  logic       i_ifu_valid,
    input  logic       i_lsu_req,
    input  logic       i_lsu_done,
    output logic       o_pc_wen,
    output logic       o_ifid_wen,
    output logic       o_ifid_bubble,
    output logic       o_idex_wen,
    output logic       o_idex_bubble,
    output logic       o_exmem_wen,
    output logic       o_exmem_bubble,
    output logic       o_memwb_wen,
    output logic       o_memwb_bubble,
    output logic [1:0] o_state
);

    localparam logic [1:0] StHold    = 2'b00;
    localparam logic [1:0] StRun     = 2'b01;
    localparam logic [1:0] StLsuWait = 2'b10;

    localparam logic [3:0] HoldInit = 4'(RST_HOLD - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       squash_q, squash_d;

    logic lsu_stall;
    logic data_hazard;

    // An ID source conflicts with a producer only if both sides are live and it is not x0.
    function automatic logic src_hit(input logic [4:0] rs, input logic ren,
                                     input logic [4:0] rd, input logic wen);
        return ren && wen && (rs != 5'd0) && (rs == rd);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StHold: begin
                if (cnt_q == 4'd0) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StRun: begin
                if (i_lsu_req && !i_lsu_done) begin
                    state_d = StLsuWait;
                end
            end
            StLsuWait: begin
                if (i_lsu_done) begin
                    state_d = StRun;
                end
            end
            default: state_d = StHold;
        endcase
    end

    assign lsu_stall = ((state_q == StLsuWait) && !i_lsu_done) ||
                       ((state_q == StRun) && i_lsu_req && !i_lsu_done);

`ifdef YSYX_22050078_FORWARD_EN
    logic unused_fwd;
    assign unused_fwd = ^{i_exmem_rd, i_exmem_rd_wen, i_memwb_rd, i_memwb_rd_wen};

    assign data_hazard = i_idex_is_load &&
        (src_hit(i_idu_rs1, i_idu_rs1_ren, i_idex_rd, i_idex_rd_wen) ||
         src_hit(i_idu_rs2, i_idu_rs2_ren, i_idex_rd, i_idex_rd_wen));
`else
    logic unused_nofwd;
    assign unused_nofwd = i_idex_is_load;

    // Regfile has no write-first bypass, so a WB producer still stalls.
    assign data_hazard =
        src_hit(i_idu_rs1, i_idu_rs1_ren, i_idex_rd,  i_idex_rd_wen)  ||
        src_hit(i_idu_rs2, i_idu_rs2_ren, i_idex_rd,  i_idex_rd_wen)  ||
        src_hit(i_idu_rs1, i_idu_rs1_ren, i_exmem_rd, i_exmem_rd_wen) ||
        src_hit(i_idu_rs2, i_idu_rs2_ren, i_exmem_rd, i_exmem_rd_wen) ||
        src_hit(i_idu_rs1, i_idu_rs1_ren, i_memwb_rd, i_memwb_rd_wen) ||
        src_hit(i_idu_rs2, i_idu_rs2_ren, i_memwb_rd, i_memwb_rd_wen);
`endif

    always_comb begin
        o_pc_wen       = 1'b1;
        o_ifid_wen     = 1'b1;
        o_ifid_bubble  = 1'b0;
        o_idex_wen     = 1'b1;
        o_idex_bubble  = 1'b0;
        o_exmem_wen    = 1'b1;
        o_exmem_bubble = 1'b0;
        o_memwb_wen    = 1'b1;
        o_memwb_bubble = 1'b0;
        squash_d       = 1'b0;
        if (state_q == StHold) begin
            o_pc_wen       = 1'b0;
            o_ifid_bubble  = 1'b1;
            o_idex_bubble  = 1'b1;
            o_exmem_bubble = 1'b1;
            o_memwb_bubble = 1'b1;
        end else if (lsu_stall) begin
            // EX stays frozen, so a pending redirect is still presented after release.
            o_pc_wen       = 1'b0;
            o_ifid_wen     = 1'b0;
            o_idex_wen     = 1'b0;
            o_exmem_wen    = 1'b0;
            o_memwb_bubble = 1'b1;
        end else if (i_exu_redirect) begin
            o_ifid_bubble = 1'b1;
            o_idex_bubble = 1'b1;
            squash_d      = 1'b1;
        end else if (data_hazard) begin
            o_pc_wen      = 1'b0;
            o_ifid_wen    = 1'b0;
            o_idex_bubble = 1'b1;
        end else if (!i_ifu_valid || squash_q) begin
            o_pc_wen      = i_ifu_valid;
            o_ifid_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StHold;
            cnt_q    <= HoldInit;
            squash_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            squash_q <= squash_d;
        end
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_ysyx_22050078_pipe_ctrl.sv
// Directed bench for ysyx_22050078_pipe_ctrl; expectations follow the build option in use.
module tb_ysyx_22050078_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, idex_rd, exmem_rd, memwb_rd;
    logic       rs1_ren, rs2_ren, idex_wen, idex_load, exmem_wen, memwb_wen;
    logic       redirect, ifu_valid, lsu_req, lsu_done;
    logic       pc_wen, ifid_wen, ifid_bub, idex_wen_o, idex_bub, exmem_wen_o, exmem_bub;
    logic       memwb_wen_o, memwb_bub;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;

    // {pc_wen, ifid wen/bub, idex wen/bub, exmem wen/bub, memwb wen/bub}
    localparam logic [8:0] CtlHold = 9'b0_11_11_11_11;
    localparam logic [8:0] CtlNorm = 9'b1_10_10_10_10;
    localparam logic [8:0] CtlLsu  = 9'b0_00_00_00_11;
    localparam logic [8:0] CtlRedir = 9'b1_11_11_10_10;
    localparam logic [8:0] CtlHaz  = 9'b0_00_11_10_10;
    localparam logic [8:0] CtlFetch = 9'b0_11_10_10_10;
    localparam logic [8:0] CtlSquash = 9'b1_11_10_10_10;

    logic [10:0] obs;
    assign obs = {state, pc_wen, ifid_wen, ifid_bub, idex_wen_o, idex_bub,
                  exmem_wen_o, exmem_bub, memwb_wen_o, memwb_bub};

    always #5 clk = ~clk;

    ysyx_22050078_pipe_ctrl #(.RST_HOLD(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_idu_rs1      (rs1),
        .i_idu_rs2      (rs2),
        .i_idu_rs1_ren  (rs1_ren),
        .i_idu_rs2_ren  (rs2_ren),
        .i_idex_rd      (idex_rd),
        .i_idex_rd_wen  (idex_wen),
        .i_idex_is_load (idex_load),
        .i_exmem_rd     (exmem_rd),
        .i_exmem_rd_wen (exmem_wen),
        .i_memwb_rd     (memwb_rd),
        .i_memwb_rd_wen (memwb_wen),
        .i_exu_redirect (redirect),
        .i_ifu_valid    (ifu_valid),
        .i_lsu_req      (lsu_req),
        .i_lsu_done     (lsu_done),
        .o_pc_wen       (pc_wen),
        .o_ifid_wen     (ifid_wen),
        .o_ifid_bubble  (ifid_bub),
        .o_idex_wen     (idex_wen_o),
        .o_idex_bubble  (idex_bub),
        .o_exmem_wen    (exmem_wen_o),
        .o_exmem_bubble (exmem_bub),
        .o_memwb_wen    (memwb_wen_o),
        .o_memwb_bubble (memwb_bub),
        .o_state        (state)
    );

    task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got state=%b ctl=%b, expected state=%b ctl=%b",
                     tag, got[10:9], got[8:0], exp[10:9], exp[8:0]);
        end
    endtask

    // Inputs are set just after a negedge; sample 1 time unit later, then move to the next cycle.
    task automatic cyc(input string tag, input logic [1:0] st, input logic [8:0] ctl);
        #1 check(tag, obs, {st, ctl});
        @(negedge clk);
    endtask

    task automatic idle();
        rs1 = 5'd0; rs2 = 5'd0; rs1_ren = 1'b0; rs2_ren = 1'b0;
        idex_rd = 5'd0; idex_wen = 1'b0; idex_load = 1'b0;
        exmem_rd = 5'd0; exmem_wen = 1'b0; memwb_rd = 5'd0; memwb_wen = 1'b0;
        redirect = 1'b0; ifu_valid = 1'b1; lsu_req = 1'b0; lsu_done = 1'b0;
    endtask

    task automatic add_x6_x5_x7();
        rs1 = 5'd5; rs1_ren = 1'b1; rs2 = 5'd7; rs2_ren = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        cyc("in_reset", 2'b00, CtlHold);
        rst = 1'b0;
        cyc("hold0", 2'b00, CtlHold);
        cyc("hold1", 2'b00, CtlHold);
        cyc("run_after_hold", 2'b01, CtlNorm);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #1 check("reset_async", obs, {2'b00, CtlHold});
        do_reset();

        // load-use: lw x5 in EX, add x6,x5,x7 in ID
        add_x6_x5_x7();
        idex_rd = 5'd5; idex_wen = 1'b1; idex_load = 1'b1;
        cyc("load_use", 2'b01, CtlHaz);
        idle();
        cyc("after_load_use", 2'b01, CtlNorm);

        // x0 destination is never a hazard
        rs1 = 5'd0; rs1_ren = 1'b1; idex_rd = 5'd0; idex_wen = 1'b1; idex_load = 1'b1;
        cyc("x0_no_hazard", 2'b01, CtlNorm);
        idle();

        // unread source does not match
        rs2 = 5'd5; rs2_ren = 1'b0; idex_rd = 5'd5; idex_wen = 1'b1; idex_load = 1'b1;
        cyc("unread_rs2", 2'b01, CtlNorm);
        idle();

        // addi x5 walking EX -> MEM -> WB with the consumer held in ID
        add_x6_x5_x7();
        idex_rd = 5'd5; idex_wen = 1'b1;
`ifdef YSYX_22050078_FORWARD_EN
        cyc("raw_ex_fwd", 2'b01, CtlNorm);
`else
        cyc("raw_ex", 2'b01, CtlHaz);
        idex_wen = 1'b0; exmem_rd = 5'd5; exmem_wen = 1'b1;
        cyc("raw_mem", 2'b01, CtlHaz);
        exmem_wen = 1'b0; memwb_rd = 5'd5; memwb_wen = 1'b1;
        cyc("raw_wb", 2'b01, CtlHaz);
        memwb_wen = 1'b0;
        cyc("raw_done", 2'b01, CtlNorm);
`endif
        idle();

        // 4-cycle LSU wait
        lsu_req = 1'b1;
        cyc("lsu_first", 2'b01, CtlLsu);
        for (int i = 0; i < 3; i++) cyc("lsu_wait", 2'b10, CtlLsu);
        lsu_done = 1'b1;
        cyc("lsu_release", 2'b10, CtlNorm);
        idle();
        cyc("lsu_after", 2'b01, CtlNorm);

        // redirect beats load-use, then one squash cycle
        add_x6_x5_x7();
        idex_rd = 5'd5; idex_wen = 1'b1; idex_load = 1'b1; redirect = 1'b1;
        cyc("redirect_vs_load_use", 2'b01, CtlRedir);
        idle();
        cyc("squash", 2'b01, CtlSquash);
        cyc("after_squash", 2'b01, CtlNorm);

        // fetch not valid
        ifu_valid = 1'b0;
        cyc("fetch_wait", 2'b01, CtlFetch);
        idle();

        // redirect during LSU wait is deferred to the release cycle
        lsu_req = 1'b1; redirect = 1'b1;
        cyc("redir_lsu_first", 2'b01, CtlLsu);
        cyc("redir_lsu_wait", 2'b10, CtlLsu);
        lsu_done = 1'b1;
        cyc("redir_lsu_release", 2'b10, CtlRedir);
        idle();
        cyc("redir_lsu_squash", 2'b01, CtlSquash);
        cyc("redir_lsu_after", 2'b01, CtlNorm);

        // reset in the middle of an LSU wait
        lsu_req = 1'b1;
        cyc("pre_rst_lsu", 2'b01, CtlLsu);
        #3 rst = 1'b1;
        #1 check("rst_mid_lsu", obs, {2'b00, CtlHold});
        idle();
        @(negedge clk);
        rst = 1'b0;
        cyc("rel_hold0", 2'b00, CtlHold);
        cyc("rel_hold1", 2'b00, CtlHold);
        cyc("rel_run", 2'b01, CtlNorm);

        // reset right after a redirect: squash must not survive
        redirect = 1'b1;
        cyc("pre_rst_redir", 2'b01, CtlRedir);
        redirect = 1'b0;
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
